// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// ALU operation codes, FSM states and datapath mux selects.
// Pure declarations, no logic.
package mips_pkg;

  // Opcodes (IR[31:26]) and the one funct (IR[5:0]) the control path cares about
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  // ALU operation codes
  localparam logic [3:0] ALU_NOP    = 4'h0;
  localparam logic [3:0] ALU_OR     = 4'h1;
  localparam logic [3:0] ALU_LUI    = 4'h2;
  localparam logic [3:0] ALU_AND    = 4'h3;
  localparam logic [3:0] ALU_ADD    = 4'h4;
  localparam logic [3:0] ALU_ADDR   = 4'h5;
  localparam logic [3:0] ALU_BEQ    = 4'h6;
  localparam logic [3:0] ALU_RTYPE  = 4'h7;
  localparam logic [3:0] ALU_BNE    = 4'h8;
  localparam logic [3:0] ALU_ADD_PC = 4'hA;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_ADDR, ST_MEM_RD, ST_MEM_WR,
    ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_JAL, ST_JR, ST_TRAP, ST_HALT
  } state_t;

  // Datapath mux selects
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG_A  = 2'd3;
  localparam logic [1:0] REG_DST_RT    = 2'd0;
  localparam logic [1:0] REG_DST_RD    = 2'd1;
  localparam logic [1:0] REG_DST_RA    = 2'd2;
  localparam logic [1:0] M2R_ALUOUT    = 2'd0;
  localparam logic [1:0] M2R_MDR       = 2'd1;
  localparam logic [1:0] M2R_PC        = 2'd2;
  localparam logic [1:0] ALUB_B        = 2'd0;
  localparam logic [1:0] ALUB_FOUR     = 2'd1;
  localparam logic [1:0] ALUB_IMM      = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2  = 2'd3;

  // States that drive the shared memory port and may stall on mem_ready
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Opcode/funct decode: which state follows DECODE and which ALU op it uses.
// Latency: combinational.
// Backpressure: none; unknown opcodes map to the trap state.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output state_t     next_state_o,
  output logic [3:0] alu_op_o
);

  // Map the instruction class onto the first post-decode state
  always_comb begin
    next_state_o = ST_TRAP;
    alu_op_o     = ALU_NOP;
    case (opcode_i)
      OP_RTYPE: begin
        if (funct_i == FN_JR) begin
          next_state_o = ST_JR;
        end else begin
          next_state_o = ST_EXEC_R;
          alu_op_o     = ALU_RTYPE;
        end
      end
      OP_ADDI: begin next_state_o = ST_EXEC_I; alu_op_o = ALU_ADD; end
      OP_ORI:  begin next_state_o = ST_EXEC_I; alu_op_o = ALU_OR;  end
      OP_LUI:  begin next_state_o = ST_EXEC_I; alu_op_o = ALU_LUI; end
      OP_ANDI: begin next_state_o = ST_EXEC_I; alu_op_o = ALU_AND; end
      OP_LW, OP_SW: begin next_state_o = ST_ADDR; alu_op_o = ALU_ADDR; end
      OP_BEQ:  begin next_state_o = ST_BRANCH; alu_op_o = ALU_BEQ; end
      OP_BNE:  begin next_state_o = ST_BRANCH; alu_op_o = ALU_BNE; end
      OP_J:    next_state_o = ST_JUMP;
      OP_JAL:  next_state_o = ST_JAL;
      default: next_state_o = ST_TRAP;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM (Moore) with wait-state, timeout and illegal-opcode traps.
// Latency: R/I 4, lw 5, sw 4, branch/jump/illegal 3 cycles, plus one per memory wait cycle.
// Backpressure: stalls in FETCH/MEM_RD/MEM_WR until mem_ready_i; halts after 2^TIMEOUT_W-1 stalls.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int ALU_OP_W  = 4,
  parameter int TIMEOUT_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode_i,
  input  logic [5:0]          funct_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                pc_write_eq_o,
  output logic                pc_write_ne_o,
  output logic [1:0]          pc_src_o,
  output logic                i_or_d_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                ir_write_o,
  output logic                reg_write_o,
  output logic [1:0]          reg_dst_o,
  output logic [1:0]          mem_to_reg_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                illegal_o,
  output logic                bus_error_o,
  output logic [CNT_W-1:0]    instr_count_o
);

  // Counter value during the last tolerated stall cycle; one more stall means timeout
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state_q, state_d, dec_next;
  logic [3:0]           dec_alu_op, alu_op_q, alu_op;
  logic                 is_r_q, is_bne_q, is_sw_q;
  logic [TIMEOUT_W-1:0] wait_q;
  logic [CNT_W-1:0]     count_q;
  logic                 wait_expired, retire;

  mips_ctrl_decode u_decode (
    .opcode_i     (opcode_i),
    .funct_i      (funct_i),
    .next_state_o (dec_next),
    .alu_op_o     (dec_alu_op)
  );

  assign wait_expired = (wait_q == WAIT_LAST);
  assign retire = (state_q == ST_WB_ALU) || (state_q == ST_WB_MEM) || (state_q == ST_BRANCH) ||
                  (state_q == ST_JUMP) || (state_q == ST_JAL) || (state_q == ST_JR) ||
                  ((state_q == ST_MEM_WR) && mem_ready_i);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; ready wins over timeout on the last tolerated stall cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready_i) state_d = ST_DECODE; else if (wait_expired) state_d = ST_HALT;
      ST_DECODE: state_d = dec_next;
      ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
      ST_ADDR:   state_d = is_sw_q ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: if (mem_ready_i) state_d = ST_WB_MEM; else if (wait_expired) state_d = ST_HALT;
      ST_MEM_WR: if (mem_ready_i) state_d = ST_FETCH;  else if (wait_expired) state_d = ST_HALT;
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_JAL, ST_JR, ST_TRAP: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Wait counter, retire counter, and decode info latched for the later states
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_q   <= '0;
      count_q  <= '0;
      alu_op_q <= ALU_NOP;
      is_r_q   <= 1'b0;
      is_bne_q <= 1'b0;
      is_sw_q  <= 1'b0;
    end else begin
      if (is_mem_state(state_q) && !mem_ready_i) wait_q <= wait_q + TIMEOUT_W'(1);
      else                                       wait_q <= '0;
      if (retire) count_q <= count_q + CNT_W'(1);
      if (state_q == ST_DECODE) begin
        alu_op_q <= dec_alu_op;
        is_r_q   <= (opcode_i == OP_RTYPE);
        is_bne_q <= (opcode_i == OP_BNE);
        is_sw_q  <= (opcode_i == OP_SW);
      end
    end
  end

  // Moore outputs; only the FETCH IR/PC load strobes follow mem_ready directly
  always_comb begin
    pc_write_o    = 1'b0;
    pc_write_eq_o = 1'b0;
    pc_write_ne_o = 1'b0;
    pc_src_o      = PC_SRC_ALU;
    i_or_d_o      = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    reg_write_o   = 1'b0;
    reg_dst_o     = REG_DST_RT;
    mem_to_reg_o  = M2R_ALUOUT;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = ALUB_B;
    alu_op        = ALU_NOP;
    illegal_o     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = ALUB_FOUR;
        alu_op      = ALU_ADD_PC;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      ST_DECODE: begin
        alu_src_b_o = ALUB_IMM_SH2;
        alu_op      = ALU_ADD_PC;
      end
      ST_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op      = ALU_RTYPE;
      end
      ST_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALUB_IMM;
        alu_op      = alu_op_q;
      end
      ST_WB_ALU: begin
        reg_write_o = 1'b1;
        reg_dst_o   = is_r_q ? REG_DST_RD : REG_DST_RT;
      end
      ST_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALUB_IMM;
        alu_op      = ALU_ADDR;
      end
      ST_MEM_RD: begin i_or_d_o = 1'b1; mem_read_o  = 1'b1; end
      ST_MEM_WR: begin i_or_d_o = 1'b1; mem_write_o = 1'b1; end
      ST_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_MDR;
      end
      ST_BRANCH: begin
        alu_src_a_o   = 1'b1;
        pc_src_o      = PC_SRC_ALUOUT;
        alu_op        = is_bne_q ? ALU_BNE : ALU_BEQ;
        pc_write_eq_o = !is_bne_q;
        pc_write_ne_o = is_bne_q;
      end
      ST_JUMP: begin pc_write_o = 1'b1; pc_src_o = PC_SRC_JUMP; end
      ST_JAL: begin
        pc_write_o   = 1'b1;
        pc_src_o     = PC_SRC_JUMP;
        reg_write_o  = 1'b1;
        reg_dst_o    = REG_DST_RA;
        mem_to_reg_o = M2R_PC;
      end
      ST_JR:   begin pc_write_o = 1'b1; pc_src_o = PC_SRC_REG_A; end
      ST_TRAP: illegal_o = 1'b1;
      default: ;
    endcase
  end

  assign alu_op_o      = ALU_OP_W'(alu_op);
  assign bus_error_o   = (state_q == ST_HALT);
  assign instr_count_o = count_q;

endmodule
